decomp_sequencer: RTL and testbench
===================================

# decomp_sequencer

Top-level sequencer and SRAM bus owner for the image decompressor. It runs the fixed stage order UART load → M2 (IDCT/dequantise) → M1 (upsample + colour convert) → display. Each stage engine gets a level enable, and its done pulse is collected. One combinational mux hands the single external SRAM port to exactly one stage at a time. A guard cycle separates stage handoffs, and a per-stage watchdog forces an error state if a stage never finishes.

## Interface
- WDT_CYCLES, default 22'd4194303: maximum cycles a stage may stay active before an error is declared.
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  reset; one clock; synchronous, active-high.
- Start  in  1  one-cycle pulse requesting a full decode run.
- Load_done, M2_done, M1_done  in  1 each  one-cycle completion pulses from the engines.
- Load_enable, M2_enable, M1_enable  out  1 each  level enables to the engines.
- Load_SRAM_address / M2_SRAM_address / M1_SRAM_address  in  18  engine address requests.
- Load_SRAM_write_data / M2_SRAM_write_data / M1_SRAM_write_data  in  16  engine write data.
- Load_SRAM_we_n / M2_SRAM_we_n / M1_SRAM_we_n  in  1  engine write enables, active-low.
- VGA_SRAM_address  in  18  display read address.
- SRAM_address  out  18  to the SRAM controller.
- SRAM_write_data  out  16  to the SRAM controller.
- SRAM_we_n  out  1  to the SRAM controller, active-low.
- Busy  out  1  high in LOAD, M2, M1 and GUARD.
- Error  out  1  high only in ERROR.
- Stage  out  3  encoding of the current state.

## Operation
- States: S_SEQ_IDLE(0), S_SEQ_LOAD(1), S_SEQ_M2(2), S_SEQ_M1(3), S_SEQ_GUARD(4), S_SEQ_DISPLAY(5), S_SEQ_ERROR(6).
- IDLE: Start → LOAD.
- LOAD: Load_done → GUARD, with next-stage register = M2.
- M2: M2_done → GUARD, with next-stage register = M1.
- M1: M1_done → GUARD, with next-stage register = DISPLAY.
- GUARD: lasts exactly one cycle, then moves to the next-stage register.
- DISPLAY: Start → LOAD, beginning a new run.
- ERROR: Start → LOAD; nothing else leaves ERROR except Reset.
- Start in LOAD, M2, M1 or GUARD is ignored.
- A done pulse from a non-active engine is ignored.
- Each enable is high only while in its own stage. It is decoded from the registered state, so it drops on the edge where the state leaves that stage.
- SRAM mux (combinational, zero added latency):
  - LOAD, M2, M1: the active engine's address, write data and we_n pass straight through.
  - DISPLAY: VGA_SRAM_address passes through; SRAM_we_n forced 1.
  - IDLE, GUARD, ERROR: SRAM_address = 0, SRAM_write_data = 0, SRAM_we_n = 1.
- Watchdog (22-bit):
  - Cleared on entry to LOAD, M2 or M1; increments each cycle in that stage.
  - Reaching WDT_CYCLES with no done pulse → ERROR.
  - A done pulse and the timeout in the same cycle: done wins.
- Reset, including mid-stage: the next edge gives state IDLE, all enables 0, watchdog 0, Error 0, SRAM_we_n 1. An interrupted engine simply sees its enable fall.

## Timing
- Reset values: all enables 0, Busy 0, Error 0, Stage 0, SRAM_address 0, SRAM_write_data 0, SRAM_we_n 1.
- Start sampled at edge N: Stage = 1 and Load_enable = 1 from N+1.
- Done sampled at edge N: Stage = 4 at N+1; the next enable rises at N+2.
- Handoff gap is therefore exactly one cycle with no enable and no write.
- SRAM read latency seen by the engines is unchanged by the sequencer.
- Timeout: the stage entered at edge E reaches ERROR at edge E+WDT_CYCLES.

## Structure
- Shared state package/header:
  - seq_state_type enum, next to the existing milestone state enums.
  - Stage encodings.
  - Memory-map constants shared with the engines: Y base 0, U base 38400, V base 57600, RGB base 146944.
- One sub-module, stage_watchdog: 22-bit counter with clear, enable and timeout output.

## Test plan
- Reset asserted → Stage 0, SRAM_we_n 1, all enables 0 on the first edge.
- Full run:
  - Start pulse; Load_done at cycle 10, M2_done at cycle 30, M1_done at cycle 50.
  - Required: Stage sequence 1, 4, 2, 4, 3, 4, 5.
  - Each enable high only within its window; exactly one guard cycle with SRAM_we_n = 1 at each handoff.
- Mux check:
  - In M1, drive M1_SRAM_address = 18'd146944, write data 16'hABCD, we_n 0 → identical values on the SRAM outputs.
  - In DISPLAY, drive VGA address 18'h3FFFF with M1_SRAM_we_n = 0 → SRAM_address 18'h3FFFF and SRAM_we_n 1.
- Stray done pulses:
  - M1_done during LOAD → ignored, Stage stays 1.
  - Start during M2 → ignored.
- Watchdog with WDT_CYCLES = 100:
  - No M2_done → Error = 1 and Stage = 6 exactly 100 cycles after entering M2; all enables 0.
  - A following Start → Stage 1.
  - Variant: M2_done exactly on the timeout cycle → Stage 4, no error.
- Reset mid-M1 → Stage 0 and M1_enable 0 on the next edge; a later Start runs the full sequence cleanly.

Source files
------------

// File: rtl/decomp_sequencer_pkg.sv
// Shared decoder definitions: sequencer state encodings, watchdog width and the
// frame-buffer memory map used by the stage engines.
package decomp_sequencer_pkg;

  localparam int WDT_W = 22;

  // The Stage output carries these encodings directly.
  typedef enum logic [2:0] {
    S_SEQ_IDLE    = 3'd0,
    S_SEQ_LOAD    = 3'd1,
    S_SEQ_M2      = 3'd2,
    S_SEQ_M1      = 3'd3,
    S_SEQ_GUARD   = 3'd4,
    S_SEQ_DISPLAY = 3'd5,
    S_SEQ_ERROR   = 3'd6
  } seq_state_type;

  localparam logic [17:0] Y_BASE   = 18'd0;
  localparam logic [17:0] U_BASE   = 18'd38400;
  localparam logic [17:0] V_BASE   = 18'd57600;
  localparam logic [17:0] RGB_BASE = 18'd146944;

  function automatic logic is_engine_stage(input seq_state_type s);
    return (s == S_SEQ_LOAD) || (s == S_SEQ_M2) || (s == S_SEQ_M1);
  endfunction

endpackage

// File: rtl/decomp_sequencer_stage_watchdog.sv
// Per-stage cycle counter; timeout is raised on the last cycle a stage may
// remain active, so the owner leaves on the edge ending that cycle.
module stage_watchdog
  import decomp_sequencer_pkg::*;
#(
  parameter logic [WDT_W-1:0] LIMIT = 22'd4194303
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  logic [WDT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // count holds k during the k-th cycle after entry, so the edge after count
  // reaches LIMIT-1 is exactly LIMIT edges past the entry edge.
  assign timeout = en && (count >= (LIMIT - 1'b1));

endmodule

// File: rtl/decomp_sequencer.sv
// Decoder top-level sequencer: runs LOAD -> M2 -> M1 -> DISPLAY with a guard
// cycle at each handoff and owns the single SRAM port through a combinational mux.
module decomp_sequencer
  import decomp_sequencer_pkg::*;
#(
  parameter logic [WDT_W-1:0] WDT_CYCLES = 22'd4194303
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Load_done,
  input  logic        M2_done,
  input  logic        M1_done,
  output logic        Load_enable,
  output logic        M2_enable,
  output logic        M1_enable,
  input  logic [17:0] Load_SRAM_address,
  input  logic [17:0] M2_SRAM_address,
  input  logic [17:0] M1_SRAM_address,
  input  logic [15:0] Load_SRAM_write_data,
  input  logic [15:0] M2_SRAM_write_data,
  input  logic [15:0] M1_SRAM_write_data,
  input  logic        Load_SRAM_we_n,
  input  logic        M2_SRAM_we_n,
  input  logic        M1_SRAM_we_n,
  input  logic [17:0] VGA_SRAM_address,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        Busy,
  output logic        Error,
  output logic [2:0]  Stage
);

  seq_state_type state, state_next;
  seq_state_type next_stage, next_stage_next;
  logic          active;
  logic          timeout;

  assign active = is_engine_stage(state);

  stage_watchdog #(
    .LIMIT(WDT_CYCLES)
  ) u_watchdog (
    .clk    (Clock),
    .rst    (Reset),
    .clr    (!active),
    .en     (active),
    .timeout(timeout)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= S_SEQ_IDLE;
      next_stage <= S_SEQ_IDLE;
    end else begin
      state      <= state_next;
      next_stage <= next_stage_next;
    end
  end

  // Done is tested before timeout so a completion on the final cycle still wins.
  always_comb begin
    state_next      = state;
    next_stage_next = next_stage;
    case (state)
      S_SEQ_IDLE: if (Start) state_next = S_SEQ_LOAD;
      S_SEQ_LOAD: begin
        if (Load_done) begin
          state_next      = S_SEQ_GUARD;
          next_stage_next = S_SEQ_M2;
        end else if (timeout) begin
          state_next = S_SEQ_ERROR;
        end
      end
      S_SEQ_M2: begin
        if (M2_done) begin
          state_next      = S_SEQ_GUARD;
          next_stage_next = S_SEQ_M1;
        end else if (timeout) begin
          state_next = S_SEQ_ERROR;
        end
      end
      S_SEQ_M1: begin
        if (M1_done) begin
          state_next      = S_SEQ_GUARD;
          next_stage_next = S_SEQ_DISPLAY;
        end else if (timeout) begin
          state_next = S_SEQ_ERROR;
        end
      end
      S_SEQ_GUARD:   state_next = next_stage;
      S_SEQ_DISPLAY: if (Start) state_next = S_SEQ_LOAD;
      S_SEQ_ERROR:   if (Start) state_next = S_SEQ_LOAD;
      default:       state_next = S_SEQ_IDLE;
    endcase
  end

  assign Load_enable = (state == S_SEQ_LOAD);
  assign M2_enable   = (state == S_SEQ_M2);
  assign M1_enable   = (state == S_SEQ_M1);
  assign Busy        = active || (state == S_SEQ_GUARD);
  assign Error       = (state == S_SEQ_ERROR);
  assign Stage       = state;

  // Idle, guard and error park the bus on a harmless read of address 0.
  always_comb begin
    SRAM_address    = '0;
    SRAM_write_data = '0;
    SRAM_we_n       = 1'b1;
    case (state)
      S_SEQ_LOAD: begin
        SRAM_address    = Load_SRAM_address;
        SRAM_write_data = Load_SRAM_write_data;
        SRAM_we_n       = Load_SRAM_we_n;
      end
      S_SEQ_M2: begin
        SRAM_address    = M2_SRAM_address;
        SRAM_write_data = M2_SRAM_write_data;
        SRAM_we_n       = M2_SRAM_we_n;
      end
      S_SEQ_M1: begin
        SRAM_address    = M1_SRAM_address;
        SRAM_write_data = M1_SRAM_write_data;
        SRAM_we_n       = M1_SRAM_we_n;
      end
      S_SEQ_DISPLAY: SRAM_address = VGA_SRAM_address;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_decomp_sequencer.sv
// Directed/randomized bench for decomp_sequencer: expected stage timelines come
// from the run schedule, and expected bus values from which stage owns the SRAM.
module tb_decomp_sequencer;

  logic        Clock = 1'b0;
  logic        Reset, Start, Load_done, M2_done, M1_done;
  logic        Load_enable, M2_enable, M1_enable;
  logic [17:0] Load_SRAM_address, M2_SRAM_address, M1_SRAM_address, VGA_SRAM_address;
  logic [15:0] Load_SRAM_write_data, M2_SRAM_write_data, M1_SRAM_write_data;
  logic        Load_SRAM_we_n, M2_SRAM_we_n, M1_SRAM_we_n;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n, Busy, Error;
  logic [2:0]  Stage;

  int n_checks = 0;
  int n_fail   = 0;

  decomp_sequencer #(.WDT_CYCLES(22'd100)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start),
    .Load_done(Load_done), .M2_done(M2_done), .M1_done(M1_done),
    .Load_enable(Load_enable), .M2_enable(M2_enable), .M1_enable(M1_enable),
    .Load_SRAM_address(Load_SRAM_address), .M2_SRAM_address(M2_SRAM_address),
    .M1_SRAM_address(M1_SRAM_address),
    .Load_SRAM_write_data(Load_SRAM_write_data), .M2_SRAM_write_data(M2_SRAM_write_data),
    .M1_SRAM_write_data(M1_SRAM_write_data),
    .Load_SRAM_we_n(Load_SRAM_we_n), .M2_SRAM_we_n(M2_SRAM_we_n), .M1_SRAM_we_n(M1_SRAM_we_n),
    .VGA_SRAM_address(VGA_SRAM_address),
    .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n),
    .Busy(Busy), .Error(Error), .Stage(Stage)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs follow from which stage is current: 1/2/3 hand the bus to
  // their engine, 5 to the display (read only), anything else parks it.
  task automatic check_outputs(input int exp);
    logic [17:0] ea;
    logic [15:0] ed;
    logic        ew;
    ea = '0; ed = '0; ew = 1'b1;
    case (exp)
      1: begin ea = Load_SRAM_address; ed = Load_SRAM_write_data; ew = Load_SRAM_we_n; end
      2: begin ea = M2_SRAM_address;   ed = M2_SRAM_write_data;   ew = M2_SRAM_we_n;   end
      3: begin ea = M1_SRAM_address;   ed = M1_SRAM_write_data;   ew = M1_SRAM_we_n;   end
      5: ea = VGA_SRAM_address;
      default: ;
    endcase
    chk("stage",     {29'd0, Stage}, exp);
    chk("load_en",   {31'd0, Load_enable}, {31'd0, exp == 1});
    chk("m2_en",     {31'd0, M2_enable},   {31'd0, exp == 2});
    chk("m1_en",     {31'd0, M1_enable},   {31'd0, exp == 3});
    chk("busy",      {31'd0, Busy},        {31'd0, (exp >= 1) && (exp <= 4)});
    chk("error",     {31'd0, Error},       {31'd0, exp == 6});
    chk("sram_addr", {14'd0, SRAM_address},    {14'd0, ea});
    chk("sram_data", {16'd0, SRAM_write_data}, {16'd0, ed});
    chk("sram_we_n", {31'd0, SRAM_we_n},       {31'd0, ew});
  endtask

  task automatic randomize_bus();
    Load_SRAM_address    = 18'($urandom);
    M2_SRAM_address      = 18'($urandom);
    M1_SRAM_address      = 18'($urandom);
    VGA_SRAM_address     = 18'($urandom);
    Load_SRAM_write_data = 16'($urandom);
    M2_SRAM_write_data   = 16'($urandom);
    M1_SRAM_write_data   = 16'($urandom);
    Load_SRAM_we_n       = 1'($urandom);
    M2_SRAM_we_n         = 1'($urandom);
    M1_SRAM_we_n         = 1'($urandom);
  endtask

  task automatic step(input int exp);
    randomize_bus();
    @(posedge Clock);
    #1;
    check_outputs(exp);
  endtask

  task automatic clear_pulses();
    Start = 1'b0; Load_done = 1'b0; M2_done = 1'b0; M1_done = 1'b0;
  endtask

  task automatic start_run();
    Start = 1'b1;
    step(1);
    Start = 1'b0;
  endtask

  // Stay in stage `code` for `cycles` more edges, then its done edge gives the
  // guard stage, and the following edge gives `nxt`.
  task automatic run_stage(input int code, input int cycles, input int nxt, input bit strays);
    for (int i = 0; i < cycles; i++) begin
      if (strays && ($urandom_range(0, 2) == 0)) begin
        Start     = 1'($urandom_range(0, 1));
        Load_done = (code != 1) && ($urandom_range(0, 1) == 1);
        M2_done   = (code != 2) && ($urandom_range(0, 1) == 1);
        M1_done   = (code != 3) && ($urandom_range(0, 1) == 1);
      end
      step(code);
      clear_pulses();
    end
    case (code)
      1: Load_done = 1'b1;
      2: M2_done   = 1'b1;
      default: M1_done = 1'b1;
    endcase
    step(4);
    clear_pulses();
    step(nxt);
  endtask

  task automatic stray_steps(input int exp, input int n);
    for (int i = 0; i < n; i++) begin
      Load_done = 1'($urandom_range(0, 1));
      M2_done   = 1'($urandom_range(0, 1));
      M1_done   = 1'($urandom_range(0, 1));
      step(exp);
      clear_pulses();
    end
  endtask

  initial begin
    clear_pulses();
    randomize_bus();
    Reset = 1'b1;
    step(0);
    step(0);
    Reset = 1'b0;
    stray_steps(0, 4);

    // Directed run: Load_done at cycle 10, M2_done at 30, M1_done at 50.
    start_run();
    M1_done = 1'b1;
    step(1);
    M1_done = 1'b0;
    run_stage(1, 8, 2, 1'b0);
    Start = 1'b1;
    step(2);
    Start = 1'b0;
    run_stage(2, 17, 3, 1'b0);
    M1_SRAM_address    = 18'd146944;
    M1_SRAM_write_data = 16'hABCD;
    M1_SRAM_we_n       = 1'b0;
    #1;
    chk("mux_m1_addr", {14'd0, SRAM_address}, 32'd146944);
    chk("mux_m1_data", {16'd0, SRAM_write_data}, 32'hABCD);
    chk("mux_m1_we_n", {31'd0, SRAM_we_n}, 32'd0);
    run_stage(3, 18, 5, 1'b0);
    VGA_SRAM_address = 18'h3FFFF;
    M1_SRAM_we_n     = 1'b0;
    #1;
    chk("mux_vga_addr", {14'd0, SRAM_address}, 32'h3FFFF);
    chk("mux_vga_we_n", {31'd0, SRAM_we_n}, 32'd1);
    stray_steps(5, 5);

    // M2 never finishes: error exactly 100 edges after entry.
    start_run();
    run_stage(1, 5, 2, 1'b1);
    for (int i = 0; i < 99; i++) begin
      Load_done = 1'($urandom_range(0, 1));
      M1_done   = 1'($urandom_range(0, 1));
      step(2);
      clear_pulses();
    end
    step(6);
    stray_steps(6, 5);
    start_run();

    // Done arriving on the timeout cycle itself.
    run_stage(1, 3, 2, 1'b0);
    run_stage(2, 99, 3, 1'b1);
    run_stage(3, 99, 5, 1'b0);
    stray_steps(5, 2);

    // Reset in the middle of M1, then a clean run.
    start_run();
    run_stage(1, 2, 2, 1'b0);
    run_stage(2, 2, 3, 1'b0);
    step(3);
    step(3);
    Reset = 1'b1;
    step(0);
    Reset = 1'b0;
    stray_steps(0, 3);
    start_run();
    run_stage(1, 9, 2, 1'b1);
    run_stage(2, 18, 3, 1'b1);
    run_stage(3, 18, 5, 1'b1);

    // Randomized runs of varying stage lengths.
    for (int r = 0; r < 6; r++) begin
      start_run();
      run_stage(1, $urandom_range(0, 40), 2, 1'b1);
      run_stage(2, $urandom_range(0, 40), 3, 1'b1);
      run_stage(3, $urandom_range(0, 40), 5, 1'b1);
      stray_steps(5, $urandom_range(0, 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
